// File: rtl/bcd_conv_pkg.sv
// ============================================================================
// Package : bcd_conv_pkg
// Brief   : Shared types and constants for the BCD <-> binary converters.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int         BCD_W   = 4;

   // Never returns less than 1, so a single-digit build still gets a counter bit.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mac10.sv
// ============================================================================
// Module : bcd_mac10
// Brief  : Combinational acc*10 + d step with overflow and bad-digit flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mac10
   import bcd_conv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [3:0]       d,
   output logic [WIDTH-1:0] nxt,
   output logic             carry,
   output logic             bad
);

   logic [WIDTH+3:0] w_acc_ext;
   logic [WIDTH+3:0] w_wide;

   assign w_acc_ext = {4'b0000, acc};

   // x*10 as x*8 + x*2; four guard bits are enough to hold 15 + 10*(2^WIDTH-1).
   assign w_wide = (w_acc_ext << 3) + (w_acc_ext << 1) + {{WIDTH{1'b0}}, d};

   assign nxt   = w_wide[WIDTH-1:0];
   assign carry = |w_wide[WIDTH+3:WIDTH];
   assign bad   = (d > BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module : bcd_to_binary_seq
// Brief  : Serial BCD-to-binary converter, one digit per cycle, MSD first,
//          with valid/ready handshakes on input and output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq
   import bcd_conv_pkg::*;
#(
   parameter int DIGITS = 10,
   parameter int WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_bin,
   output logic                  out_ovf,
   output logic                  out_err
);

   localparam int            SHW      = DIGITS * BCD_W;
   localparam int            CW       = clog2(DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_live;
   logic [SHW-1:0]     r_sh;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_acc;
   logic               r_ovf;
   logic               r_err;

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_bin;
   logic               r_out_ovf;
   logic               r_out_err;

   logic               w_in_ready;
   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_step;
   logic               w_last;

   logic [3:0]         w_digit;
   logic [WIDTH-1:0]   w_nxt;
   logic               w_carry;
   logic               w_bad;

   assign w_digit = r_sh[SHW-1 -: BCD_W];

   bcd_mac10 #(
      .WIDTH (WIDTH)
   ) u_mac (
      .acc   (r_acc),
      .d     (w_digit),
      .nxt   (w_nxt),
      .carry (w_carry),
      .bad   (w_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_in_fire   = 1'b0;
      w_out_fire  = 1'b0;
      w_step      = 1'b0;
      w_last      = (r_cnt == '0);
      case (r_state)
         ST_IDLE: begin
            w_in_ready = r_live;
            if (r_live && in_valid) begin
               w_in_fire   = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_out_fire  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Keeps in_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh  <= '0;
         r_cnt <= '0;
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else if (w_in_fire) begin
         r_sh  <= in_bcd;
         r_cnt <= CNT_LAST;
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else if (w_step) begin
         r_sh  <= r_sh << BCD_W;
         r_acc <= w_nxt;
         r_ovf <= r_ovf | w_carry;
         r_err <= r_err | w_bad;
         if (!w_last) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Results are loaded straight from the final MAC step so DONE shows them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_bin   <= '0;
         r_out_ovf   <= 1'b0;
         r_out_err   <= 1'b0;
      end else if (w_step && w_last) begin
         r_out_valid <= 1'b1;
         r_out_bin   <= w_nxt;
         r_out_ovf   <= r_ovf | w_carry;
         r_out_err   <= r_err | w_bad;
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_bin   = r_out_bin;
   assign out_ovf   = r_out_ovf;
   assign out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// Module : tb_bcd_to_binary_seq
// Brief  : Self-checking bench for bcd_to_binary_seq against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

   localparam int DIGITS = 10;
   localparam int WIDTH  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [39:0]       in_bcd;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_bin;
   logic              out_ovf;
   logic              out_err;

   int                chk_cnt  = 0;
   int                pass_cnt = 0;
   int                cyc      = 0;
   logic [33:0]       exp_q[$];

   logic              rnd_rdy  = 1'b0;
   logic              tp_chk   = 1'b0;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(
      .DIGITS (DIGITS),
      .WIDTH  (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Decimal value by plain positional arithmetic; result is {err, ovf, bin}.
   function automatic logic [33:0] model(input logic [39:0] b);
      longint unsigned v;
      logic            err;
      logic [3:0]      d;
      v   = 0;
      err = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         d = b[4*k +: 4];
         v = v * 10 + longint'(d);
         if (d > 4'd9) err = 1'b1;
      end
      return {err, (v > 64'hFFFF_FFFF), v[31:0]};
   endfunction

   function automatic logic [39:0] rnd_bcd();
      logic [39:0] b;
      int          mode;
      mode = int'($urandom_range(0, 7));
      b    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (mode == 0)      b[4*k +: 4] = 4'($urandom_range(0, 15));
         else if (mode == 1) b[4*k +: 4] = 4'd9;
         else                b[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if (mode == 2) b[39:36] = 4'd4;
      if (mode == 3) b[39:20] = '0;
      return b;
   endfunction

   // Compare process: sampled on the falling edge, away from the active edge.
   logic        hold = 1'b0;
   logic [31:0] prev_bin;
   logic        prev_ovf, prev_err;
   int          lat = 0;
   logic        lat_on = 1'b0;
   int          tp_last = 0;
   logic        tp_have = 1'b0;

   always @(negedge clk) begin
      logic [33:0] e;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         hold   = 1'b0;
         lat_on = 1'b0;
      end else begin
         if (lat_on) begin
            lat++;
            if (out_valid) begin
               chk("latency", 64'(lat), 64'(DIGITS + 1));
               lat_on = 1'b0;
            end
         end
         if (out_valid) chk("in_ready_while_valid", 64'(in_ready), 64'd0);
         if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_bin", 64'(out_bin), 64'(prev_bin));
            chk("hold_flags", 64'({out_ovf, out_err}), 64'({prev_ovf, prev_err}));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("model_bin", 64'(out_bin), 64'(e[31:0]));
               chk("model_ovf", 64'(out_ovf), 64'(e[32]));
               chk("model_err", 64'(out_err), 64'(e[33]));
            end
         end
         hold     = out_valid && !out_ready;
         prev_bin = out_bin;
         prev_ovf = out_ovf;
         prev_err = out_err;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_bcd));
            lat    = 0;
            lat_on = 1'b1;
            if (tp_chk && tp_have) chk("throughput", 64'(cyc - tp_last), 64'(DIGITS + 2));
            tp_last = cyc;
            tp_have = tp_chk;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [39:0] b);
      int k;
      in_bcd   = b;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      chk("accept_wait", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int k;
      k = 0;
      while (!out_valid && k < 200) begin
         tick();
         k++;
      end
      chk("out_wait", 64'(out_valid), 64'd1);
   endtask

   task automatic run(input logic [39:0] b, input logic [31:0] eb, input logic eo, input logic ee);
      send(b);
      wait_out();
      chk("lit_bin", 64'(out_bin), 64'(eb));
      chk("lit_ovf", 64'(out_ovf), 64'(eo));
      chk("lit_err", 64'(out_err), 64'(ee));
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bcd    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_outputs", 64'({out_bin, out_ovf, out_err}), 64'd0);
      #3 rst_n = 1'b1;
      #1 chk("rel_in_ready_low", 64'(in_ready), 64'd0);
      tick();
      chk("rel_in_ready_high", 64'(in_ready), 64'd1);

      run(40'h0000000001, 32'd1, 1'b0, 1'b0);
      run(40'h0000000002, 32'd2, 1'b0, 1'b0);
      run(40'h0000000000, 32'd0, 1'b0, 1'b0);
      run(40'h0001234102, 32'h0012D4B6, 1'b0, 1'b0);
      run(40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0);
      run(40'h4294967296, 32'h00000000, 1'b1, 1'b0);
      run(40'h9999999999, 32'h540BE3FF, 1'b1, 1'b0);

      // Invalid digit plus an in_valid pulse that must be ignored mid-conversion.
      send(40'h00000000A5);
      tick();
      chk("run_in_ready", 64'(in_ready), 64'd0);
      in_bcd   = 40'h0000000077;
      in_valid = 1'b1;
      tick();
      chk("run_pulse_ignored", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0;
      wait_out();
      chk("bad_bin", 64'(out_bin), 64'd105);
      chk("bad_ovf", 64'(out_ovf), 64'd0);
      chk("bad_err", 64'(out_err), 64'd1);
      tick();
      seen = 0;
      repeat (15) begin
         tick();
         if (out_valid) seen++;
      end
      chk("no_extra_output", 64'(seen), 64'd0);

      // Back-pressure: result must sit still until out_ready.
      out_ready = 1'b0;
      send(40'h0000012345);
      wait_out();
      repeat (20) begin
         tick();
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      chk("stall_bin", 64'(out_bin), 64'd12345);
      out_ready = 1'b1;
      tick();
      chk("release_valid_drop", 64'(out_valid), 64'd0);
      tick();
      chk("release_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back conversions with out_ready held high.
      tp_chk = 1'b1;
      send(40'h0000000123);
      send(40'h0000045678);
      send(40'h3000000001);
      wait_out();
      tick();
      tp_chk = 1'b0;
      tick();

      // Abort in the middle of RUN.
      send(40'h0987654321);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_bin", 64'(out_bin), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1 chk("abort_rel_in_ready", 64'(in_ready), 64'd0);
      tick();
      seen = 0;
      repeat (15) begin
         if (out_valid) seen++;
         tick();
      end
      chk("abort_no_partial", 64'(seen), 64'd0);
      run(40'h0000000042, 32'd42, 1'b0, 1'b0);

      // Randomized traffic with random back-pressure.
      rnd_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(rnd_bcd());
      end
      rnd_rdy = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (30) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
